// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and state encoding for the interrupt controller
package irq_ctrl_pkg;

    // Register offsets from the block base address
    localparam logic [1:0] OFS_MASK    = 2'd0;
    localparam logic [1:0] OFS_PENDING = 2'd1;
    localparam logic [1:0] OFS_VECTOR  = 2'd2;
    localparam logic [1:0] OFS_CTRL    = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN = 0;  // global interrupt enable
    localparam int CTRL_RR = 1;  // 0 fixed priority, 1 round-robin

    // One-hot service FSM encoding
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ARB   = 4'b0010,
        ST_RAISE = 4'b0100,
        ST_ACK   = 4'b1000
    } state_t;

endpackage

// File: rtl/irq_rr_picker.sv
// rtl/irq_rr_picker.sv - combinational fixed / round-robin request picker
//
// Ports:
//   req   in   NUM_SRC  active requests (pending & mask)
//   ptr   in   3        round-robin start index, always < NUM_SRC
//   mode  in   1        0 = lowest index wins, 1 = search starts at ptr and wraps
//   id    out  3        selected request index (0 when none)
//   any   out  1        at least one request is active
module irq_rr_picker #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         ptr,
    input  logic               mode,
    output logic [2:0]         id,
    output logic               any
);

    logic [7:0] req_ext;
    int         idx;
    logic [2:0] idx3;

    // Widen to 8 bits so a 3-bit index always selects a valid bit.
    assign req_ext = 8'(req);

    always_comb begin
        id   = '0;
        any  = 1'b0;
        idx  = 0;
        idx3 = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (mode ? int'(ptr) : 0) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx3 = 3'(idx);
            // First hit in search order wins.
            if (!any && req_ext[idx3]) begin
                any = 1'b1;
                id  = idx3;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - bus-mapped interrupt controller with fixed / round-robin arbitration
//
// Ports:
//   CLK            in     1        system clock
//   RESET          in     1        asynchronous active-low reset
//   BUS_DATA       inout  8        shared data bus, driven one cycle after a selected read
//   BUS_ADDR       in     8        shared address bus
//   BUS_WE         in     1        1 = write, 0 = read
//   SRC_RAISE      in     NUM_SRC  per-source request, rising edge captured
//   SRC_ACK        out    NUM_SRC  one-cycle acknowledge to the serviced source
//   CPU_INT_RAISE  out    1        interrupt request to the processor
//   CPU_INT_ACK    in     1        processor acknowledge pulse
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         NUM_SRC   = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_RAISE,
    output logic [NUM_SRC-1:0] SRC_ACK,
    output logic               CPU_INT_RAISE,
    input  logic               CPU_INT_ACK
);

    localparam logic [2:0] LAST_ID = 3'(NUM_SRC - 1);

    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] raise_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] bus_in;
    logic [NUM_SRC-1:0] vec_onehot;
    logic [1:0]         ctrl;

    logic [7:0] ofs_full;
    logic [1:0] ofs;
    logic       sel;
    logic       wr_mask;
    logic       wr_pending;
    logic       wr_ctrl;
    logic [7:0] rd_val;
    logic [7:0] rd_data;
    logic       rd_en;

    state_t     state;
    logic [2:0] vec_id;
    logic [2:0] rr_ptr;
    logic [2:0] pick_id;
    logic       pick_any;
    logic       cpu_raise;
    logic [NUM_SRC-1:0] src_ack;

    // Address decode: subtraction handles bases that are not 4-aligned.
    assign ofs_full   = BUS_ADDR - BASE_ADDR;
    assign sel        = (ofs_full < 8'd4);
    assign ofs        = ofs_full[1:0];
    assign wr_mask    = sel && BUS_WE && (ofs == OFS_MASK);
    assign wr_pending = sel && BUS_WE && (ofs == OFS_PENDING);
    assign wr_ctrl    = sel && BUS_WE && (ofs == OFS_CTRL);
    assign bus_in     = BUS_DATA[NUM_SRC-1:0];

    assign rise       = SRC_RAISE & ~raise_q;
    assign vec_onehot = NUM_SRC'(1) << vec_id;

    // Clears first, then the new edge, so a simultaneous set wins.
    always_comb begin
        pending_nxt = pending;
        if (wr_pending) begin
            pending_nxt = pending_nxt & ~bus_in;
        end
        if (state == ST_ACK) begin
            pending_nxt = pending_nxt & ~vec_onehot;
        end
        pending_nxt = pending_nxt | rise;
    end

    always_comb begin
        rd_val = '0;
        case (ofs)
            OFS_MASK:    rd_val = 8'(mask);
            OFS_PENDING: rd_val = 8'(pending);
            OFS_VECTOR:  rd_val = {(state == ST_RAISE), 4'b0000, vec_id};
            OFS_CTRL:    rd_val = {6'b000000, ctrl};
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mask    <= '0;
            pending <= '0;
            ctrl    <= '0;
            raise_q <= '0;
            rd_data <= '0;
            rd_en   <= 1'b0;
        end else begin
            raise_q <= SRC_RAISE;
            pending <= pending_nxt;
            if (wr_mask) begin
                mask <= bus_in;
            end
            if (wr_ctrl) begin
                ctrl <= BUS_DATA[1:0];
            end
            rd_en   <= sel && !BUS_WE;
            rd_data <= rd_val;
        end
    end

    irq_rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req  (pending & mask),
        .ptr  (rr_ptr),
        .mode (ctrl[CTRL_RR]),
        .id   (pick_id),
        .any  (pick_any)
    );

    // Once the vector is latched the service runs to completion: mask, enable
    // and PENDING writes no longer influence RAISE/ACK.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            vec_id    <= '0;
            rr_ptr    <= '0;
            cpu_raise <= 1'b0;
            src_ack   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl[CTRL_EN] && |(pending & mask)) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    // Requests may vanish via W1C between IDLE and ARB.
                    if (pick_any) begin
                        vec_id    <= pick_id;
                        cpu_raise <= 1'b1;
                        state     <= ST_RAISE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RAISE: begin
                    if (CPU_INT_ACK) begin
                        cpu_raise <= 1'b0;
                        src_ack   <= vec_onehot;
                        state     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    src_ack <= '0;
                    if (ctrl[CTRL_RR]) begin
                        rr_ptr <= (vec_id == LAST_ID) ? 3'd0 : vec_id + 3'd1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_raise <= 1'b0;
                    src_ack   <= '0;
                end
            endcase
        end
    end

    assign SRC_ACK       = src_ack;
    assign CPU_INT_RAISE = cpu_raise;
    assign BUS_DATA      = rd_en ? rd_data : 8'bzzzz_zzzz;

endmodule
